logarithm_scanner: RTL and testbench
====================================

LOGARITHM_SCANNER -- requirements
Module: logarithm_scanner

Interface
REQ-001: Parameter BIN_SIZE, default 8, SHALL be the width of the scanned input vector, with a legal range of 2 to 64.
REQ-002: Parameter BOUT_SIZE, default 3, SHALL be the width of the index output and SHALL be at least clog2(BIN_SIZE); smaller values are illegal.
REQ-003: Parameter MSB_FIRST, default 0, SHALL select the scan order: 0 reports the lowest set bit first, 1 reports the highest set bit first.
REQ-004: Port list, with clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_vector is presented.
- in_ready  output  1  block can accept a vector.
- in_vector  input  BIN_SIZE  vector to scan.
- out_valid  output  1  out_index holds a valid index.
- out_ready  input  1  consumer accepts out_index.
- out_index  output  BOUT_SIZE  bit position of the current set bit.
- out_last  output  1  current index is the final set bit of the vector.
- zero  output  1  one-cycle pulse: an all-zero vector was accepted.
- busy  output  1  scan in progress.

Function
REQ-005: The block SHALL implement exactly two states, IDLE and SCAN, and SHALL hold a BIN_SIZE-bit register rem containing the not-yet-reported set bits.
REQ-006: in_ready SHALL be 1 in IDLE and 0 in SCAN, decoded combinationally from the state only; busy SHALL equal NOT in_ready.
REQ-007: IDLE with in_valid=1 and a nonzero in_vector SHALL load rem with in_vector and move to SCAN on that edge.
REQ-008: IDLE with in_valid=1 and in_vector=0 SHALL register zero=1 for exactly the following cycle and stay in IDLE; out_valid SHALL remain 0.
REQ-009: Back-to-back zero vectors SHALL produce zero=1 on each corresponding following cycle.
REQ-010: In SCAN, out_valid SHALL be 1, and out_index SHALL be the index of the lowest set bit of rem when MSB_FIRST=0, or of the highest set bit when MSB_FIRST=1.
REQ-011: out_index SHALL be zero-extended to BOUT_SIZE.
REQ-012: In SCAN, out_last SHALL be 1 exactly when rem has a single set bit.
REQ-013: A handshake occurs when out_valid=1 and out_ready=1; on that edge the reported bit SHALL be cleared in rem.
REQ-014: If out_last=1 at the handshake, the block SHALL return to IDLE on that edge.
REQ-015: While out_valid=1 and out_ready=0, out_index and out_last SHALL hold stable.
REQ-016: in_valid and in_vector SHALL be ignored in SCAN; they are not captured and cause no side effects.
REQ-017: Timing for a vector accepted at edge N:
- the first index SHALL be valid in the cycle after edge N;
- with out_ready held at 1, k set bits SHALL yield k consecutive indices;
- in_ready SHALL return to 1 in the cycle after the last handshake.
REQ-018: Outside SCAN, out_valid and out_last SHALL be 0 and out_index SHALL be 0.
REQ-019: zero SHALL be 0 in every cycle not covered by REQ-008.

Reset
REQ-020: While rst_n=0, regardless of clk, the state SHALL be IDLE, rem SHALL be 0, and out_valid, out_last, out_index and zero SHALL be 0.
REQ-021: Assertion of rst_n in the middle of a scan SHALL abort the scan; no remaining indices SHALL be emitted after release.
REQ-022: After rst_n rises, in_ready SHALL be 1 in the first cycle.

Verification
REQ-023: With MSB_FIRST=0, BIN_SIZE=8, in_vector=8'b1010_0100 and out_ready=1, the bench SHALL check out_index 2,5,7 on consecutive cycles, out_last=1 only with 7, and in_ready=1 on the next cycle.
REQ-024: With MSB_FIRST=1 and the same vector, the bench SHALL check out_index 7,5,2, with out_last=1 on 2.
REQ-025: With in_vector=8'h00 accepted, the bench SHALL check zero=1 for one cycle, out_valid=0 throughout, and in_ready staying at 1.
REQ-026: With in_vector=8'h81 and out_ready=0 for 3 cycles, the bench SHALL check out_index=0 held stable with out_last=0; after out_ready=1, the sequence SHALL be 0 then 7, with out_last on 7.
REQ-027: With in_vector=8'hFF and in_valid kept at 1 with changing data during SCAN, the bench SHALL check indices 0..7 on 8 consecutive cycles, with the new data ignored until in_ready=1.
REQ-028: With 8'hFF loaded, rst_n=0 asserted asynchronously after two handshakes, the bench SHALL check out_valid=0 immediately, no further indices after release, and in_ready=1.

Source files
------------

// File: rtl/logarithm_scanner.sv
// ---------------------------------------------------------------------------
// logarithm_scanner
//
// Accepts a BIN_SIZE-bit vector and emits the positions of its set bits, one
// per output handshake. The scan order is lowest-bit-first (MSB_FIRST=0) or
// highest-bit-first (MSB_FIRST=1). An all-zero vector produces no indices.
// Instead, it raises a one-cycle 'zero' pulse.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_vector is presented
//   in_ready   block can accept a vector (IDLE)
//   in_vector  vector to scan
//   out_valid  out_index holds a valid index (SCAN)
//   out_ready  consumer accepts out_index
//   out_index  bit position of the current set bit, zero-extended
//   out_last   current index is the final set bit of the vector
//   zero       one-cycle pulse after an all-zero vector was accepted
//   busy       scan in progress
//
// Legal parameters: 2 <= BIN_SIZE <= 64 and BOUT_SIZE >= clog2(BIN_SIZE).
// ---------------------------------------------------------------------------
module logarithm_scanner #(
  parameter int BIN_SIZE  = 8,
  parameter int BOUT_SIZE = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_SIZE-1:0]  in_vector,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BOUT_SIZE-1:0] out_index,
  output logic                 out_last,
  output logic                 zero,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               state_reg;
  logic [BIN_SIZE-1:0]  rem_reg;    // set bits not yet reported
  logic                 zero_reg;

  logic [BOUT_SIZE-1:0] pick_index; // position of the bit to report now
  logic [BIN_SIZE-1:0]  pick_mask;  // one-hot mask of that bit
  logic                 single_bit; // rem_reg holds exactly one set bit

  // Priority pick. The loop runs toward the preferred end, so the last
  // match seen is the one reported: ascending for highest-first,
  // descending for lowest-first.
  always_comb begin
    pick_index = '0;
    pick_mask  = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < BIN_SIZE; i++) begin
        if (rem_reg[i]) begin
          pick_index   = BOUT_SIZE'(i);
          pick_mask    = '0;
          pick_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = BIN_SIZE - 1; i >= 0; i--) begin
        if (rem_reg[i]) begin
          pick_index   = BOUT_SIZE'(i);
          pick_mask    = '0;
          pick_mask[i] = 1'b1;
        end
      end
    end
  end

  // A value with exactly one set bit is nonzero and has x & (x-1) == 0.
  assign single_bit = (rem_reg != '0) &&
                      ((rem_reg & (rem_reg - BIN_SIZE'(1))) == '0);

  // All outputs decode from state_reg and rem_reg, so they are
  // glitch-free and cleared as soon as reset is asserted.
  assign in_ready  = (state_reg == IDLE);
  assign busy      = ~in_ready;
  assign out_valid = (state_reg == SCAN);
  assign out_index = (state_reg == SCAN) ? pick_index : '0;
  assign out_last  = (state_reg == SCAN) && single_bit;
  assign zero      = zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      zero_reg  <= 1'b0;
    end else begin
      zero_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (in_vector != '0) begin
              rem_reg   <= in_vector;
              state_reg <= SCAN;
            end else begin
              zero_reg <= 1'b1;
            end
          end
        end
        SCAN: begin
          // In SCAN, the input side is ignored entirely.
          if (out_ready) begin
            rem_reg <= rem_reg & ~pick_mask;
            if (single_bit) begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          rem_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logarithm_scanner.sv
// ---------------------------------------------------------------------------
// tb_logarithm_scanner
//
// Directed bench. It holds two instances, one lowest-first and one
// highest-first, and drives both with the same inputs. Inputs change one
// time unit after a rising edge. Outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_logarithm_scanner;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_vector;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_last0, zero0, busy0;
  logic [2:0] out_index0;
  logic       in_ready1, out_valid1, out_last1, zero1, busy1;
  logic [2:0] out_index1;

  int checks = 0;
  int errors = 0;

  logarithm_scanner #(.BIN_SIZE(8), .BOUT_SIZE(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_vector(in_vector),
    .out_valid(out_valid0), .out_ready(out_ready), .out_index(out_index0),
    .out_last(out_last0), .zero(zero0), .busy(busy0)
  );

  logarithm_scanner #(.BIN_SIZE(8), .BOUT_SIZE(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_vector(in_vector),
    .out_valid(out_valid1), .out_ready(out_ready), .out_index(out_index1),
    .out_last(out_last1), .zero(zero1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vector = 8'h00;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", in_ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_index", out_index0, 0);
    check("rst_out_last", out_last0, 0);
    check("rst_zero", zero0, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready0, 1);
    $display("reset released: in_ready=%0b", in_ready0);

    // A4 with ready held high: lowest-first gives 2,5,7 and highest-first gives 7,5,2
    in_valid  = 1'b1;
    in_vector = 8'hA4;
    tick();
    in_valid = 1'b0;
    check("a4_in_ready", in_ready0, 0);
    check("a4_busy", busy0, 1);
    check("a4_valid0", out_valid0, 1);
    check("a4_lsb_idx0", out_index0, 2);
    check("a4_lsb_last0", out_last0, 0);
    check("a4_msb_idx0", out_index1, 7);
    check("a4_msb_last0", out_last1, 0);
    tick();
    check("a4_lsb_idx1", out_index0, 5);
    check("a4_lsb_last1", out_last0, 0);
    check("a4_msb_idx1", out_index1, 5);
    check("a4_msb_last1", out_last1, 0);
    tick();
    check("a4_lsb_idx2", out_index0, 7);
    check("a4_lsb_last2", out_last0, 1);
    check("a4_msb_idx2", out_index1, 2);
    check("a4_msb_last2", out_last1, 1);
    tick();
    check("a4_done_in_ready", in_ready0, 1);
    check("a4_done_valid", out_valid0, 0);
    check("a4_done_index", out_index0, 0);
    check("a4_done_last", out_last0, 0);
    check("a4_done_msb_in_ready", in_ready1, 1);
    $display("vector a4 scanned: in_ready=%0b", in_ready0);

    // Two back-to-back zero vectors
    in_valid  = 1'b1;
    in_vector = 8'h00;
    tick();
    check("z_pulse0", zero0, 1);
    check("z_valid0", out_valid0, 0);
    check("z_in_ready0", in_ready0, 1);
    tick();
    in_valid = 1'b0;
    check("z_pulse1", zero0, 1);
    check("z_valid1", out_valid0, 0);
    tick();
    check("z_pulse_end", zero0, 0);
    check("z_valid_end", out_valid0, 0);
    check("z_in_ready_end", in_ready0, 1);
    $display("zero vectors: zero=%0b", zero0);

    // 81 with a stalled consumer
    in_valid  = 1'b1;
    in_vector = 8'h81;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("81_stall_idx", out_index0, 0);
      check("81_stall_last", out_last0, 0);
      check("81_stall_valid", out_valid0, 1);
      if (s < 2) tick();
    end
    out_ready = 1'b1;
    check("81_idx0", out_index0, 0);
    tick();
    check("81_idx1", out_index0, 7);
    check("81_last1", out_last0, 1);
    tick();
    check("81_done_in_ready", in_ready0, 1);
    $display("vector 81 scanned after stall");

    // FF while in_valid stays high with changing data
    in_valid  = 1'b1;
    in_vector = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_vector = (i % 2 == 1) ? 8'h00 : 8'h3C;
      check("ff_idx", out_index0, 64'(i));
      check("ff_last", out_last0, (i == 7) ? 1 : 0);
      check("ff_zero", zero0, 0);
      check("ff_in_ready", in_ready0, 0);
      tick();
    end
    check("ff_done_in_ready", in_ready0, 1);
    check("ff_done_valid", out_valid0, 0);
    in_vector = 8'h10;
    tick();
    in_valid = 1'b0;
    check("ff_next_idx", out_index0, 4);
    check("ff_next_last", out_last0, 1);
    tick();
    check("ff_next_in_ready", in_ready0, 1);
    $display("vector ff scanned with busy input ignored");

    // Reset in the middle of an FF scan
    in_valid  = 1'b1;
    in_vector = 8'hFF;
    tick();
    in_valid = 1'b0;
    check("rs_idx0", out_index0, 0);
    tick();
    check("rs_idx1", out_index0, 1);
    tick();
    check("rs_idx2", out_index0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_async_valid", out_valid0, 0);
    check("rs_async_index", out_index0, 0);
    check("rs_async_in_ready", in_ready0, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rs_after_valid", out_valid0, 0);
    check("rs_after_in_ready", in_ready0, 1);
    tick();
    check("rs_after_valid2", out_valid0, 0);
    check("rs_after_msb_valid", out_valid1, 0);
    $display("reset during scan aborted it");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
